// File: rtl/get_tanh_pipe.sv
// get_tanh_pipe: streaming fixed-point tanh(x), Q(DATA_W-FRAC_W).FRAC_W in and out.
// Piecewise-linear evaluation over [0,4) with odd symmetry and saturation to +/-1.0.
// Four register stages feed a first-word-fall-through result FIFO. A credit counter
// reserves a FIFO slot at accept time, so the pipeline itself never has to stall.
// The {slope,intercept} table is generated at elaboration from an exact tanh
// recurrence. INIT_FILE names the equivalent hex image and tags the overflow message.
module get_tanh_pipe #(
    parameter int    DATA_W    = 32,
    parameter int    FRAC_W    = 16,
    parameter int    SEG_BITS  = 6,
    parameter int    COEF_W    = 18,
    parameter int    DEPTH     = 8,
    parameter string INIT_FILE = "tanh_pwl.hex"
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] argdata,
    output logic              busy,
    output logic              done,
    input  logic              stall,
    output logic [DATA_W-1:0] returndata
);

    localparam int SEGS   = 1 << SEG_BITS;
    localparam int F_W    = FRAC_W + 2 - SEG_BITS;   // offset bits inside one segment
    localparam int CF     = COEF_W - 2;              // fraction bits of the table words
    localparam int ROM_W  = 2 * COEF_W;
    localparam int PROD_W = COEF_W + F_W;
    localparam int SUM_W  = COEF_W + FRAC_W + 1;
    localparam int Y_W    = SUM_W - CF;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    // Table of chords through tanh at the segment end points. tanh of one segment
    // width comes from repeated doubling of a tiny argument (where tanh(h) ~ h),
    // and the end points from the addition formula, all in Q30.
    function automatic logic [SEGS*ROM_W-1:0] build_rom();
        logic [SEGS*ROM_W-1:0] img;
        longint one;
        longint step;
        longint t0;
        longint t1;
        longint icpt;
        longint slope;
        one  = longint'(1) << 30;
        step = longint'(1) << 18;
        for (int i = 0; i < 14 - SEG_BITS; i++)
            step = ((2 * step) << 30) / (one + ((step * step) >> 30));
        img = '0;
        t0  = 0;
        for (int k = 0; k < SEGS; k++) begin
            t1    = ((t0 + step) << 30) / (one + ((t0 * step) >> 30));
            icpt  = (t0 + (longint'(1) << (29 - CF))) >> (30 - CF);
            slope = (((t1 - t0) << SEG_BITS) + (longint'(1) << (31 - CF))) >> (32 - CF);
            img[k*ROM_W +: ROM_W] = {COEF_W'(slope), COEF_W'(icpt)};
            t0 = t1;
        end
        return img;
    endfunction

    localparam logic [SEGS*ROM_W-1:0] ROM_IMAGE = build_rom();
    localparam logic [DATA_W-1:0]     MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]     MOST_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [Y_W-1:0]        ONE_Y     = Y_W'(1) << FRAC_W;
    localparam logic [SUM_W-1:0]      HALF_LSB  = SUM_W'(1) << (CF - 1);

    logic                accept;
    logic                pop;
    logic                push;
    logic [CNT_W-1:0]    credit_cnt;
    logic [CNT_W-1:0]    count;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   mag_c;
    logic                v0, neg0, sat0;
    logic [SEG_BITS-1:0] idx0;
    logic [F_W-1:0]      f0;
    logic                v1, neg1, sat1;
    logic [F_W-1:0]      f1;
    logic [ROM_W-1:0]    rom_q;
    logic                v2, neg2, sat2;
    logic [COEF_W-1:0]   icpt2;
    logic [PROD_W-1:0]   prod2;
    logic [SUM_W-1:0]    sum_c;
    logic [Y_W-1:0]      y_c;
    logic [Y_W-1:0]      mag_y;
    logic [DATA_W-1:0]   res_c;
    logic                v3;
    logic [DATA_W-1:0]   res3;

    assign busy       = (credit_cnt == '0);
    assign accept     = start && !busy;
    assign done       = (count != '0);
    assign pop        = done && !stall;
    assign push       = v3;
    assign returndata = done ? mem[rd_ptr] : '0;

    // Magnitude of the argument; the most negative code has no positive twin and saturates anyway.
    always_comb begin
        mag_c = argdata;
        if (argdata[DATA_W-1]) begin
            if (argdata == MOST_NEG) mag_c = MOST_POS;
            else                     mag_c = -argdata;
        end
    end

    // S0: split |x| into sign, saturation flag, segment index and in-segment offset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v0   <= 1'b0;
            neg0 <= 1'b0;
            sat0 <= 1'b0;
            idx0 <= '0;
            f0   <= '0;
        end else begin
            v0   <= accept;
            neg0 <= argdata[DATA_W-1];
            sat0 <= |mag_c[DATA_W-1:FRAC_W+2];
            idx0 <= mag_c[FRAC_W+1 -: SEG_BITS];
            f0   <= mag_c[F_W-1:0];
        end
    end

    // S1: registered table read of the segment's {slope,intercept}.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1    <= 1'b0;
            neg1  <= 1'b0;
            sat1  <= 1'b0;
            f1    <= '0;
            rom_q <= '0;
        end else begin
            v1    <= v0;
            neg1  <= neg0;
            sat1  <= sat0;
            f1    <= f0;
            rom_q <= ROM_IMAGE[idx0 * ROM_W +: ROM_W];
        end
    end

    // S2: full-precision slope * offset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v2    <= 1'b0;
            neg2  <= 1'b0;
            sat2  <= 1'b0;
            icpt2 <= '0;
            prod2 <= '0;
        end else begin
            v2    <= v1;
            neg2  <= neg1;
            sat2  <= sat1;
            icpt2 <= rom_q[COEF_W-1:0];
            prod2 <= PROD_W'(rom_q[ROM_W-1:COEF_W]) * PROD_W'(f1);
        end
    end

    // S3 datapath: align intercept, add product, round half-up, clamp to 1.0, restore sign.
    always_comb begin
        sum_c = (SUM_W'(icpt2) << FRAC_W) + SUM_W'(prod2) + HALF_LSB;
        y_c   = Y_W'(sum_c >> CF);
        mag_y = (sat2 || (y_c > ONE_Y)) ? ONE_Y : y_c;
        res_c = neg2 ? -DATA_W'(mag_y) : DATA_W'(mag_y);
    end

    // S3 register: finished result, written into the FIFO on the following edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v3   <= 1'b0;
            res3 <= '0;
        end else begin
            v3   <= v2;
            res3 <= res_c;
        end
    end

    // FIFO storage; the read side is gated by count, so the array needs no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= res3;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Credits: free FIFO slots not yet claimed by an accepted call.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit_cnt <= CNT_W'(DEPTH);
        end else begin
            if (accept && !pop)      credit_cnt <= credit_cnt - CNT_W'(1);
            else if (pop && !accept) credit_cnt <= credit_cnt + CNT_W'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
                                    !(push && (count == CNT_W'(DEPTH)) && !pop))
        else $error("get_tanh_pipe[%s]: result written into a full FIFO", INIT_FILE);

endmodule

// File: tb/tb_get_tanh_pipe.sv
// Directed and streamed checks of get_tanh_pipe against constants and a real-valued tanh.
module tb_get_tanh_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] argdata;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] returndata;

    int errors = 0;
    int checks = 0;

    logic [31:0] args[$];
    logic [31:0] got[$];

    typedef struct {
        logic [31:0] x;
        int          expv;
        int          tol;
        string       name;
    } vec_t;
    vec_t vecs[13];

    get_tanh_pipe #(
        .DATA_W(32), .FRAC_W(16), .SEG_BITS(6), .COEF_W(18), .DEPTH(8),
        .INIT_FILE("tanh_pwl.hex")
    ) dut (
        .clock(clock), .reset(reset), .start(start), .argdata(argdata),
        .busy(busy), .done(done), .stall(stall), .returndata(returndata)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int tanh_model(input logic [31:0] x);
        real xr;
        real e;
        real t;
        xr = $itor($signed(x)) / 65536.0;
        if (xr > 20.0)  return 65536;
        if (xr < -20.0) return -65536;
        e = $exp(2.0 * xr);
        t = (e - 1.0) / (e + 1.0);
        return int'(t * 65536.0);
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_tol(input string name, input logic [31:0] x, input logic [31:0] act,
                             input int expv, input int tol);
        int diff;
        checks++;
        diff = int'($signed(act)) - expv;
        if (diff > tol || diff < -tol) begin
            errors++;
            $display("FAIL %s: x=%h got %h expected %h +/- %0d", name, x, act, expv, tol);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] x, input int expv, input int tol,
                           input string name);
        vecs[i].x    = x;
        vecs[i].expv = expv;
        vecs[i].tol  = tol;
        vecs[i].name = name;
    endtask

    // Enters and leaves just after a rising edge. lat counts edges from the accept edge
    // (inclusive) to the first edge after which done is visible.
    task automatic single_call(input logic [31:0] x, output logic [31:0] y, output int lat);
        start   = 1'b1;
        argdata = x;
        @(posedge clock); #1;
        start   = 1'b0;
        argdata = '0;
        lat = 1;
        while (lat < 30) begin
            @(negedge clock);
            if (done) break;
            lat++;
            @(posedge clock); #1;
        end
        y = returndata;
        @(posedge clock); #1;
    endtask

    task automatic run_stream(input int start_pct, input int stall_pct, input int budget,
                              input string name);
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        got.delete();
        while ((sent < args.size() || got.size() < args.size()) && cyc < budget) begin
            start   = (sent < args.size()) && ($urandom_range(99) < start_pct);
            argdata = (sent < args.size()) ? args[sent] : '0;
            stall   = ($urandom_range(99) < stall_pct);
            @(negedge clock);
            if (start && !busy)  sent++;
            if (done && !stall)  got.push_back(returndata);
            @(posedge clock); #1;
            cyc++;
        end
        start   = 1'b0;
        stall   = 1'b0;
        argdata = '0;
        repeat (8) begin
            @(negedge clock);
            if (done) got.push_back(returndata);
            @(posedge clock); #1;
        end
        checks++;
        if (got.size() != args.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d results expected %0d", name, got.size(), args.size());
        end
    endtask

    logic [31:0] y;
    logic [31:0] bp_args[8];
    int          lat;
    int          acc;
    logic        seen;

    initial begin
        set_vec(0,  32'h0000_0000, 0,       0,  "vec_zero");
        set_vec(1,  32'h0005_0000, 65536,   0,  "vec_sat_pos5");
        set_vec(2,  32'hFFFB_0000, -65536,  0,  "vec_sat_neg5");
        set_vec(3,  32'h8000_0000, -65536,  0,  "vec_most_neg");
        set_vec(4,  32'h7FFF_FFFF, 65536,   0,  "vec_most_pos");
        set_vec(5,  32'h0004_0000, 65536,   0,  "vec_exact_4");
        set_vec(6,  32'hFFFC_0000, -65536,  0,  "vec_exact_neg4");
        set_vec(7,  32'h0001_0000, 49913,   64, "vec_one");
        set_vec(8,  32'hFFFF_0000, -49913,  64, "vec_neg_one");
        set_vec(9,  32'h0000_8000, 30285,   64, "vec_half");
        set_vec(10, 32'h0003_FFFF, 65492,   64, "vec_below_4");
        set_vec(11, 32'h0000_1000, 4091,    64, "vec_seg1_edge");
        set_vec(12, 32'hFFFF_FFFF, -1,      64, "vec_neg_lsb");

        reset   = 1'b1;
        start   = 1'b0;
        stall   = 1'b0;
        argdata = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_data", returndata, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("idle_done", 32'(done), 0);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_data", returndata, 0);
        @(posedge clock); #1;

        // x=0: latency and exact zero, popped immediately
        single_call(32'h0, y, lat);
        check_eq("lat_zero", 32'(lat), 5);
        check_eq("data_zero", y, 32'h0);
        @(negedge clock);
        check_eq("popped_zero", 32'(done), 0);
        @(posedge clock); #1;

        for (int i = 0; i < 13; i++) begin
            single_call(vecs[i].x, y, lat);
            check_tol(vecs[i].name, vecs[i].x, y, vecs[i].expv, vecs[i].tol);
        end

        // reset with three calls in flight
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            argdata = 32'h0001_0000 + 32'(i) * 32'h100;
            @(posedge clock); #1;
        end
        start   = 1'b0;
        argdata = '0;
        #2 reset = 1'b1;
        @(negedge clock);
        check_eq("midrst_done", 32'(done), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_data", returndata, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            @(posedge clock); #1;
        end
        check_eq("midrst_no_done", 32'(seen), 0);
        check_eq("midrst_credits", 32'(dut.credit_cnt), 8);

        // sweep over +/-4.5, full rate
        args.delete();
        for (int i = 0; i <= 576; i++) args.push_back(32'(-294912 + i * 1024));
        run_stream(100, 0, 2000, "sweep");
        for (int i = 0; i < got.size() && i < args.size(); i++)
            check_tol("sweep_acc", args[i], got[i], tanh_model(args[i]), 64);
        if (got.size() == 577) begin
            for (int i = 0; i <= 288; i++)
                check_eq("sweep_odd", got[i], -got[576 - i]);
        end

        // backpressure: fill with stall held, then drain
        for (int k = 0; k < 8; k++) bp_args[k] = 32'(k + 1) * 32'h2000;
        stall = 1'b1;
        acc   = 0;
        for (int c = 0; c < 16; c++) begin
            start   = 1'b1;
            argdata = (acc < 8) ? bp_args[acc] : 32'h0007_0000;
            @(negedge clock);
            if (start && !busy) acc++;
            @(posedge clock); #1;
        end
        start   = 1'b0;
        argdata = '0;
        @(negedge clock);
        check_eq("bp_accepted", 32'(acc), 8);
        check_eq("bp_busy_full", 32'(busy), 1);
        check_eq("bp_done_full", 32'(done), 1);
        @(posedge clock); #1;
        stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check_eq("bp_rate", 32'(done), 1);
            check_tol("bp_order", bp_args[k], returndata, tanh_model(bp_args[k]), 64);
            if (k == 0) check_eq("bp_busy_before_pop", 32'(busy), 1);
            if (k == 1) check_eq("bp_busy_after_pop", 32'(busy), 0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check_eq("bp_no_extra", 32'(done), 0);
        check_eq("bp_credits", 32'(dut.credit_cnt), 8);
        @(posedge clock); #1;

        // random start/stall, 10k calls
        args.delete();
        for (int i = 0; i < 10000; i++)
            args.push_back(32'($urandom_range(589824)) - 32'd294912);
        run_stream(50, 50, 60000, "rand");
        for (int i = 0; i < got.size() && i < args.size(); i++)
            check_tol("rand_order", args[i], got[i], tanh_model(args[i]), 64);
        check_eq("rand_credits", 32'(dut.credit_cnt), 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
